// File: rtl/cam_lvds_align.sv
// Per-camera word-alignment trainer: slips each deserializer lane until it shows the training pattern.
// Define CAM_LVDS_ALIGN_SLIP_STATS_EN to report per-lane slip counts on slip_count (otherwise tied to 0).
module cam_lvds_align #(
    parameter int               LANES         = 5,
    parameter int               DESER         = 8,
    parameter logic [DESER-1:0] TRAIN_PATTERN = 8'hE9,
    parameter int               MATCH_COUNT   = 16,
    parameter int               SETTLE_CYCLES = 4,
    parameter int               MAX_SLIPS     = 16
) (
    input  logic                   c,
    input  logic                   rst_n,
    input  logic                   rx_locked,
    input  logic                   restart,
    input  logic [LANES*DESER-1:0] rxd,
    output logic [LANES-1:0]       bitslip,
    output logic [LANES*DESER-1:0] rxd_out,
    output logic [LANES-1:0]       lane_aligned,
    output logic [LANES-1:0]       lane_fail,
    output logic                   aligned,
    output logic [LANES*4-1:0]     slip_count
);

    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int KW = $clog2(MAX_SLIPS + 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } lane_state_e;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            rxd_out <= '0;
            aligned <= 1'b0;
        end else begin
            rxd_out <= rxd;
            aligned <= &lane_aligned;
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lane_state_e      state_q, state_d;
        logic [MW-1:0]    match_q, match_d;
        logic [SW-1:0]    settle_q, settle_d;
        logic [KW-1:0]    slip_q, slip_d;
        logic             bitslip_q, aligned_q, fail_q;
        logic [DESER-1:0] word;
        logic             hit;

        assign word = rxd[n*DESER +: DESER];
        assign hit  = (word == TRAIN_PATTERN);

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            state_d  = state_q;
            match_d  = match_q;
            settle_d = settle_q;
            slip_d   = slip_q;
            if (restart || !rx_locked) begin
                // Restart/lock loss outranks every other transition, including a pending lock.
                state_d  = ST_WAIT_LOCK;
                match_d  = '0;
                settle_d = '0;
                slip_d   = '0;
            end else begin
                unique case (state_q)
                    ST_WAIT_LOCK: state_d = ST_CHECK;
                    ST_CHECK: begin
                        if (hit) begin
                            if (match_q >= MW'(MATCH_COUNT - 1)) begin
                                match_d = MW'(MATCH_COUNT);
                                state_d = ST_LOCKED;
                            end else begin
                                match_d = match_q + 1'b1;
                            end
                        end else begin
                            match_d = '0;
                            state_d = (slip_q >= KW'(MAX_SLIPS)) ? ST_FAIL : ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        if (slip_q < KW'(MAX_SLIPS)) begin
                            slip_d = slip_q + 1'b1;
                        end
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_q >= SW'(SETTLE_CYCLES - 1)) begin
                            settle_d = SW'(SETTLE_CYCLES);
                            state_d  = ST_CHECK;
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                    ST_LOCKED: state_d = ST_LOCKED;
                    ST_FAIL:   state_d = ST_FAIL;
                    default:   state_d = ST_WAIT_LOCK;
                endcase
            end
        end

        // Flags are registered from the next state so they line up exactly with the state register.
        always_ff @(posedge c or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_WAIT_LOCK;
                match_q   <= '0;
                settle_q  <= '0;
                slip_q    <= '0;
                bitslip_q <= 1'b0;
                aligned_q <= 1'b0;
                fail_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                match_q   <= match_d;
                settle_q  <= settle_d;
                slip_q    <= slip_d;
                bitslip_q <= (state_d == ST_SLIP);
                aligned_q <= (state_d == ST_LOCKED);
                fail_q    <= (state_d == ST_FAIL);
            end
        end

        assign bitslip[n]      = bitslip_q;
        assign lane_aligned[n] = aligned_q;
        assign lane_fail[n]    = fail_q;

`ifdef CAM_LVDS_ALIGN_SLIP_STATS_EN
        assign slip_count[n*4 +: 4] = (int'(slip_q) > 15) ? 4'hF : 4'(slip_q);
`else
        assign slip_count[n*4 +: 4] = 4'h0;
`endif
    end

endmodule

// File: tb/tb_cam_lvds_align.sv
// Randomized bench for cam_lvds_align: a lane-rotating deserializer stand-in plus a behavioural trainer model.
`timescale 1ns/1ps
module tb_cam_lvds_align;

    localparam int         LANES  = 5;
    localparam int         MATCH  = 16;
    localparam int         SETTLE = 4;
    localparam int         MAXS   = 16;
    localparam logic [7:0] PAT    = 8'hE9;

    logic        c = 1'b0;
    logic        rst_n;
    logic        rx_locked;
    logic        restart;
    logic [39:0] rxd;
    logic [4:0]  bitslip;
    logic [39:0] rxd_out;
    logic [4:0]  lane_aligned;
    logic [4:0]  lane_fail;
    logic        aligned;
    logic [19:0] slip_count;

    cam_lvds_align dut (
        .c            (c),
        .rst_n        (rst_n),
        .rx_locked    (rx_locked),
        .restart      (restart),
        .rxd          (rxd),
        .bitslip      (bitslip),
        .rxd_out      (rxd_out),
        .lane_aligned (lane_aligned),
        .lane_fail    (lane_fail),
        .aligned      (aligned),
        .slip_count   (slip_count)
    );

    always #5 c = ~c;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Channel: each lane shows the pattern rotated left by rot[n]; a slip rotates it back one bit.
    int rot[LANES];
    bit zero_lane[LANES];
    bit noisy[LANES];

    // Behavioural lane model: blind window after each slip, run of matches, slip budget.
    bit m_live[LANES], m_pulse[LANES], m_lock[LANES], m_fail[LANES];
    int m_blind[LANES], m_run[LANES], m_slips[LANES];

    // Pulse statistics collected from the DUT outputs.
    int pulses[LANES], last_pulse[LANES], min_gap[LANES];
    bit prev_bs[LANES];
    int wide;
    int cyc = 0;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
        logic [7:0] x = v;
        for (int i = 0; i < r; i++) x = {x[6:0], x[7]};
        return x;
    endfunction

    function automatic logic [7:0] lane_word(input int n);
        if (zero_lane[n]) return 8'h00;
        if (noisy[n] && m_lock[n]) return 8'($urandom);
        return rotl8(PAT, rot[n]);
    endfunction

    function automatic void model_clear(input int n);
        m_live[n] = 0; m_pulse[n] = 0; m_lock[n] = 0; m_fail[n] = 0;
        m_blind[n] = 0; m_run[n] = 0; m_slips[n] = 0;
    endfunction

    function automatic void model_step(input bit lk, input bit rs, input logic [39:0] w);
        for (int n = 0; n < LANES; n++) begin
            if (rs || !lk)                 model_clear(n);
            else if (!m_live[n])           m_live[n] = 1;
            else if (m_lock[n] || m_fail[n]) begin end
            else if (m_pulse[n]) begin
                m_pulse[n] = 0;
                m_slips[n]++;
                m_blind[n] = SETTLE;
            end
            else if (m_blind[n] > 0)       m_blind[n]--;
            else if (w[n*8 +: 8] == PAT) begin
                m_run[n]++;
                if (m_run[n] == MATCH) m_lock[n] = 1;
            end else begin
                m_run[n] = 0;
                if (m_slips[n] == MAXS) m_fail[n] = 1;
                else                    m_pulse[n] = 1;
            end
        end
    endfunction

    function automatic logic [4:0] pack(input bit v[LANES]);
        logic [4:0] r;
        for (int n = 0; n < LANES; n++) r[n] = v[n];
        return r;
    endfunction

    function automatic logic [19:0] exp_slip_count();
        logic [19:0] r = '0;
`ifdef CAM_LVDS_ALIGN_SLIP_STATS_EN
        for (int n = 0; n < LANES; n++) r[n*4 +: 4] = (m_slips[n] > 15) ? 4'hF : 4'(m_slips[n]);
`endif
        return r;
    endfunction

    task automatic clear_stats();
        wide = 0;
        for (int n = 0; n < LANES; n++) begin
            pulses[n] = 0; last_pulse[n] = -1; min_gap[n] = 1000;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model and compare everything.
    task automatic step(input bit lk, input bit rs);
        logic [39:0] w;
        logic [4:0]  bs_now;
        logic        all_before;
        for (int n = 0; n < LANES; n++) w[n*8 +: 8] = lane_word(n);
        rxd = w; rx_locked = lk; restart = rs;
        bs_now     = bitslip;
        all_before = &pack(m_lock);
        @(posedge c); #1;
        cyc++;
        model_step(lk, rs, w);
        check("bitslip",      bitslip,      pack(m_pulse));
        check("lane_aligned", lane_aligned, pack(m_lock));
        check("lane_fail",    lane_fail,    pack(m_fail));
        check("aligned",      aligned,      all_before);
        check("rxd_out",      rxd_out,      w);
        check("slip_count",   slip_count,   exp_slip_count());
        for (int n = 0; n < LANES; n++) begin
            if (bs_now[n]) rot[n] = (rot[n] + 7) % 8;
            if (bitslip[n]) begin
                if (prev_bs[n]) wide++;
                else begin
                    pulses[n]++;
                    if (last_pulse[n] >= 0 && cyc - last_pulse[n] < min_gap[n]) min_gap[n] = cyc - last_pulse[n];
                    last_pulse[n] = cyc;
                end
            end
            prev_bs[n] = bitslip[n];
        end
    endtask

    task automatic run(input int ncyc);
        repeat (ncyc) step(1'b1, 1'b0);
    endtask

    task automatic run_until_aligned(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1'b1, 1'b0);
            if (aligned === 1'b1) ok = 1;
        end
        check(tag, ok, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int n = 0; n < LANES; n++) begin
            rot[n] = 0; zero_lane[n] = 0; noisy[n] = 0; prev_bs[n] = 0;
            model_clear(n);
        end
        clear_stats();

        // Reset with lock low and pattern on every lane.
        rst_n = 1'b0; rx_locked = 1'b0; restart = 1'b0; rxd = {5{PAT}};
        #23;
        check("rst_bitslip",   bitslip,      5'h00);
        check("rst_aligned_l", lane_aligned, 5'h00);
        check("rst_fail",      lane_fail,    5'h00);
        check("rst_aligned",   aligned,      1'b0);
        check("rst_rxd_out",   rxd_out,      40'h0);
        check("rst_slip_cnt",  slip_count,   20'h0);
        @(negedge c); rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);

        // All lanes already aligned: no slips.
        clear_stats();
        run_until_aligned("a_align_timeout", 60);
        check("a_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3] + pulses[4], 0);
        check("a_lanes",  lane_aligned, 5'h1F);

        // Lane 2 rotated by three bits.
        rot[2] = 3;
        step(1'b1, 1'b1);
        clear_stats();
        run_until_aligned("b_align_timeout", 300);
        check("b_pulses2", pulses[2], 3);
        check("b_gap_ok",  min_gap[2] >= SETTLE + 1, 1'b1);
        check("b_wide",    wide, 0);
`ifdef CAM_LVDS_ALIGN_SLIP_STATS_EN
        check("b_slip_cnt2", slip_count[11:8], 4'd3);
`else
        check("b_slip_cnt2", slip_count[11:8], 4'd0);
`endif

        // Lane 0 stuck at zero: exhausts its slips and fails.
        zero_lane[0] = 1;
        step(1'b1, 1'b1);
        clear_stats();
        run(200);
        check("c_pulses0", pulses[0], MAXS);
        check("c_fail",    lane_fail, 5'h01);
        check("c_lanes",   lane_aligned, 5'h1E);
        check("c_aligned", aligned, 1'b0);

        // Lock drop for one cycle after full alignment.
        zero_lane[0] = 0;
        step(1'b1, 1'b1);
        run_until_aligned("d_align_timeout", 100);
        step(1'b0, 1'b0);
        check("d_lanes_drop", lane_aligned, 5'h00);
        step(1'b1, 1'b0);
        check("d_aligned_drop", aligned, 1'b0);
        run_until_aligned("d_realign_timeout", 100);

        // Restart on the very cycle of a bitslip pulse.
        rot[3] = 2;
        step(1'b1, 1'b1);
        clear_stats();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 1'b0);
            if (bitslip[3] === 1'b1) found = 1;
        end
        check("e_pulse_seen", found, 1'b1);
        step(1'b1, 1'b1);
        check("e_pulse_cut", bitslip, 5'h00);
        check("e_wide", wide, 0);
        run_until_aligned("e_realign_timeout", 200);

        // Randomized rotations, stuck lanes, post-lock noise, lock drops and restarts.
        for (int it = 0; it < 30; it++) begin
            for (int n = 0; n < LANES; n++) begin
                rot[n]       = $urandom_range(0, 7);
                zero_lane[n] = ($urandom_range(0, 9) == 0);
                noisy[n]     = $urandom_range(0, 1) != 0;
            end
            step(1'b1, 1'b1);
            repeat ($urandom_range(20, 150))
                step($urandom_range(0, 199) != 0, $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
